// File: rtl/usb_hs_chirp_ctrl.sv
// Device-side USB high-speed detection handshake controller.
// Synchronizes the line receivers and VBUS valid, tracks how long the line has
// held one state, and walks the attach / chirp-K / host-chirp sequence to settle
// in HS or FS mode. All PHY controls are registered decodes of the state.
module usb_hs_chirp_ctrl #(
  parameter int T_SE0_DET   = 150,
  parameter int T_CHIRP_K   = 60000,
  parameter int T_FILT      = 150,
  parameter int T_WTFS      = 150000,
  parameter int CHIRP_PAIRS = 3,
  parameter int CW          = 20
) (
  input  logic       clk_60m_usb,
  input  logic       rst_n,
  input  logic       se_dp,
  input  logic       se_dm,
  input  logic       vbusvld,
  input  logic       reattach,
  output logic       rpu_dp_enable,
  output logic       hs_term_enable,
  output logic       tx_enable,
  output logic       speed_select,
  output logic       dp_bit_hs_phy,
  output logic       dm_bit_hs_phy,
  output logic       cdr_enable,
  output logic       hs_mode,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ATTACH     = 3'd1;
  localparam logic [2:0] S_CHIRP_K    = 3'd2;
  localparam logic [2:0] S_HOST_CHIRP = 3'd3;
  localparam logic [2:0] S_HS         = 3'd4;
  localparam logic [2:0] S_FS         = 3'd5;

  // Line state encoding is simply {dp, dm}.
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  localparam int CC_W = $clog2(2 * CHIRP_PAIRS + 1);

  localparam logic [CW-1:0]   SE0_DET    = CW'(T_SE0_DET);
  localparam logic [CW-1:0]   FILT       = CW'(T_FILT);
  localparam logic [CW-1:0]   CHIRP_LAST = CW'(T_CHIRP_K - 1);
  localparam logic [CW-1:0]   WTFS_LAST  = CW'(T_WTFS - 1);
  localparam logic [CC_W-1:0] CHIRP_DONE = CC_W'(2 * CHIRP_PAIRS);

  logic [2:0]      sync1, sync2;   // {vbusvld, se_dp, se_dm}
  logic [1:0]      line_cur, line_nxt;
  logic            vbus_s;
  logic [CW-1:0]   run_cnt;
  logic [CW-1:0]   timer;
  logic [CC_W-1:0] chirp_cnt;
  logic            exp_j;          // 0: expecting host K, 1: expecting host J
  logic [2:0]      state_q, state_d;
  logic            entering;
  logic            chirp_hit;
  logic [7:0]      out_d, out_q;

  assign line_cur = sync2[1:0];
  assign line_nxt = sync1[1:0];   // value line_cur takes on the next edge
  assign vbus_s   = sync2[2];
  assign entering = (state_d != state_q);
  assign chirp_hit = (state_q == S_HOST_CHIRP) && (run_cnt == FILT) &&
                     (line_cur == (exp_j ? LS_J : LS_K));

  // Two-flop synchronizers for the asynchronous line and VBUS inputs.
  always_ff @(posedge clk_60m_usb or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {vbusvld, se_dp, se_dm};
      sync2 <= sync1;
    end
  end

  // Run length of the synchronized line state, updated in step with sync2 so
  // the count already covers the cycle in which a new state first appears.
  always_ff @(posedge clk_60m_usb or negedge rst_n) begin
    if (!rst_n)                   run_cnt <= '0;
    else if (line_nxt != line_cur) run_cnt <= CW'(1);
    else if (run_cnt != '1)        run_cnt <= run_cnt + CW'(1);
  end

  // State timer and host chirp counter, both cleared on every state entry.
  always_ff @(posedge clk_60m_usb or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      chirp_cnt <= '0;
      exp_j     <= 1'b0;
    end else if (entering) begin
      timer     <= '0;
      chirp_cnt <= '0;
      exp_j     <= 1'b0;
    end else begin
      if (timer != '1) timer <= timer + CW'(1);
      if (chirp_hit && chirp_cnt != CHIRP_DONE) begin
        chirp_cnt <= chirp_cnt + CC_W'(1);
        exp_j     <= ~exp_j;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_60m_usb or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; disconnect and soft reattach override everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (vbus_s) state_d = S_ATTACH;
      S_ATTACH:     if (line_cur == LS_SE0 && run_cnt == SE0_DET) state_d = S_CHIRP_K;
      S_CHIRP_K:    if (timer == CHIRP_LAST) state_d = S_HOST_CHIRP;
      S_HOST_CHIRP: begin
        if (chirp_cnt == CHIRP_DONE)  state_d = S_HS;
        else if (timer == WTFS_LAST)  state_d = S_FS;
      end
      S_HS:         state_d = S_HS;
      S_FS:         if (line_cur == LS_SE0 && run_cnt == SE0_DET) state_d = S_CHIRP_K;
      default:      state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && (!vbus_s || reattach)) state_d = S_IDLE;
  end

  // Output decode: {rpu, hs_term, tx, speed, dp_bit, dm_bit, cdr, hs_mode}.
  always_comb begin
    out_d = 8'h00;
    case (state_q)
      S_ATTACH, S_HOST_CHIRP, S_FS: out_d = 8'b1000_0000;
      S_CHIRP_K:                    out_d = 8'b1011_0100;
      S_HS:                         out_d = 8'b0101_0011;
      default:                      out_d = 8'h00;
    endcase
  end

  // Output register; reset clears it asynchronously so tx drops at once.
  always_ff @(posedge clk_60m_usb or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign {rpu_dp_enable, hs_term_enable, tx_enable, speed_select,
          dp_bit_hs_phy, dm_bit_hs_phy, cdr_enable, hs_mode} = out_q;
  assign state = state_q;

endmodule
